p2s_frame_scheduler: RTL and testbench
======================================

# p2s_frame_scheduler

Arbitrates between NUM_REQ upstream frame producers that share a single `parallel_to_serial` converter. It loads one BUS_WIDTH-lane frame at a time and never reloads the converter while it is still draining. It also tags each serial beat with the owning requester and a last-beat marker. It sits between the per-source frame builders and the converter, and forwards the converter's serial stream downstream.

## Interface
- DW, 32, data word width per lane
- BUS_WIDTH, 12, lanes per frame (≥2)
- NUM_REQ, 2, number of requesters (≥2)
- IDX_W, 4, lane index width
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester frame valid; held with data until ready
- req_ready  out  NUM_REQ  one-hot grant pulse; handshake completes on valid&ready
- req_data  in  NUM_REQ*BUS_WIDTH*DW  flattened frames; requester r, lane l at bits [(r*BUS_WIDTH+l)*DW +: DW]
- req_idx  in  NUM_REQ*BUS_WIDTH*IDX_W  flattened lane indices, same packing
- p2s_in_valid  out  1  converter load strobe
- p2s_din  out  BUS_WIDTH*DW  muxed frame of the granted requester
- p2s_indices  out  BUS_WIDTH*IDX_W  muxed indices of the granted requester
- p2s_dout  in  DW  converter serial data
- p2s_index  in  IDX_W  converter serial index
- p2s_out_valid  in  1  converter serial valid
- ser_valid  out  1  downstream beat valid
- ser_data  out  DW  downstream data (= p2s_dout)
- ser_index  out  IDX_W  downstream index (= p2s_index)
- ser_owner  out  max(1,$clog2(NUM_REQ))  requester that owns the current frame
- ser_last  out  1  final beat of frame
- busy  out  1  state ≠ IDLE
- err  out  1  sticky protocol error

## Operation
- FSM states:
  - IDLE: if any req_valid, register the arbiter winner into `grant` and go to LOAD; otherwise stay.
  - LOAD (exactly 1 cycle): p2s_in_valid=1; req_ready[grant]=1. p2s_din/p2s_indices are muxed from `grant`. Go to DRAIN with cnt=0.
  - DRAIN: each cycle, cnt increments (width $clog2(BUS_WIDTH)). At cnt==BUS_WIDTH-1:
    - if any req_valid, register a new winner and go to LOAD;
    - otherwise go to IDLE.
- p2s_in_valid is asserted only in LOAD, so the converter is never overwritten mid-drain.
- ser_valid = p2s_out_valid & (state==DRAIN); ser_data/ser_index pass through combinationally.
- ser_owner = grant; ser_last = (state==DRAIN) & (cnt==BUS_WIDTH-1).
- err is set if p2s_out_valid==0 in any DRAIN cycle. Only reset clears it. The FSM does not change behaviour when err is set.
- Requests that arrive while busy wait; requesters must not drop req_valid before req_ready.
- When not in LOAD, p2s_din/p2s_indices drive all-ones and p2s_in_valid=0.

## Timing
- Reset values:
  - state=IDLE, cnt=0, grant=0, RR pointer=0
  - all outputs 0, except p2s_din/p2s_indices, which are all-ones
- Request to load: req_valid seen in IDLE at cycle t; LOAD in t+1; first ser_valid beat in t+2.
- Frame: BUS_WIDTH consecutive ser_valid beats, lanes 0..BUS_WIDTH-1 in order.
- Back-to-back frames: exactly one idle cycle (the LOAD cycle) between the last beat and the next frame's first beat.
- Simultaneous requests: exactly one granted per LOAD; req_ready is never multi-hot.
- A new req_valid arriving on the last DRAIN beat is eligible for that beat's arbitration.
- Reset mid-DRAIN: next cycle is IDLE with all outputs at reset values; the converter shares rstn and clears in the same cycle.

## Configuration
- P2S_SCHED_RR_EN defined: round-robin arbitration. The search starts at (last grant + 1) mod NUM_REQ; the pointer advances on every LOAD.
- Not defined: fixed priority; the lowest-numbered valid requester wins. The RR pointer logic is absent.

## Structure
- p2s_sched_pkg contains:
  - state enum {IDLE, LOAD, DRAIN}
  - default IDX_W constant
  - owner-width helper function
- Sub-module p2s_rr_arbiter (NUM_REQ): combinational winner from the request vector and pointer; its `advance` input updates the pointer. In fixed-priority builds it reduces to a priority encoder.
- Top level: FSM, counter, data mux, error flag.

## Test plan
- Single frame:
  - Stimulus: req 0 valid with lanes data=0x100+l, idx=l.
  - Response: req_ready[0] one cycle, then 12 beats with data 0x100..0x10B, idx 0..11, owner 0, ser_last on beat 12, busy low afterwards.
- Contention, RR build:
  - Stimulus: both requesters continuously valid for 4 frames.
  - Response: owner sequence 0,1,0,1; one-cycle gap between frames; req_ready never multi-hot.
- Contention, fixed-priority build:
  - Stimulus: same as the RR case.
  - Response: owner 0 for all frames while req 0 stays valid.
- Late arrival:
  - Stimulus: req 1 asserts on the last DRAIN beat of a req 0 frame.
  - Response: LOAD for req 1 on the next cycle; its first beat two cycles after the previous ser_last.
- Reset mid-drain:
  - Stimulus: rstn low at beat 5 for 1 cycle.
  - Response: next cycle busy=0, ser_valid=0, err=0; the pending request is granted after rstn rises.
- Converter fault:
  - Stimulus: force p2s_out_valid=0 on DRAIN beat 3.
  - Response: err=1 and stays 1 until reset; the frame still completes after 12 DRAIN cycles.

Source files
------------

// File: rtl/p2s_sched_pkg.sv
// Shared types for the p2s frame scheduler: FSM state encoding, default lane
// index width and the owner-field width helper.
package p2s_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   localparam int IDX_W_DEF = 4;

   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/p2s_rr_arbiter.sv
// Requester arbiter for the p2s scheduler. With P2S_SCHED_RR_EN defined it is a
// round-robin arbiter whose pointer moves past each winner on i_advance;
// otherwise it is a fixed lowest-index-wins priority encoder.
module p2s_rr_arbiter
   import p2s_sched_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int OW      = owner_w(NUM_REQ)
) (
`ifdef P2S_SCHED_RR_EN
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_advance,
`endif
   input  logic [NUM_REQ-1:0] i_req,
   output logic [OW-1:0]      o_win
);

`ifdef P2S_SCHED_RR_EN
   logic [OW-1:0] r_ptr;

   always_ff @(posedge i_clk) begin
      if (!i_rstn)
         r_ptr <= '0;
      else if (i_advance)
         r_ptr <= (int'(o_win) == NUM_REQ-1) ? '0 : o_win + 1'b1;
   end

   // Winner is the valid requester at the smallest rotated distance from r_ptr.
   always_comb begin
      int d;
      int best;
      o_win = '0;
      best  = NUM_REQ;
      d     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_req[i]) begin
            d = (i - int'(r_ptr) + NUM_REQ) % NUM_REQ;
            if (d < best) begin
               best  = d;
               o_win = OW'(i);
            end
         end
      end
   end
`else
   always_comb begin
      o_win = '0;
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (i_req[i]) o_win = OW'(i);
   end
`endif

endmodule

// File: rtl/p2s_frame_scheduler.sv
// Shares one parallel_to_serial converter among NUM_REQ frame producers and tags
// the serial stream with owner/last. P2S_SCHED_RR_EN selects round-robin arbitration.
module p2s_frame_scheduler
   import p2s_sched_pkg::*;
#(
   parameter  int DW        = 32,
   parameter  int BUS_WIDTH = 12,
   parameter  int NUM_REQ   = 2,
   parameter  int IDX_W     = IDX_W_DEF,
   localparam int OW        = owner_w(NUM_REQ),
   localparam int CW        = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*BUS_WIDTH*DW-1:0]  req_data,
   input  logic [NUM_REQ*BUS_WIDTH*IDX_W-1:0] req_idx,
   output logic                             p2s_in_valid,
   output logic [BUS_WIDTH*DW-1:0]          p2s_din,
   output logic [BUS_WIDTH*IDX_W-1:0]       p2s_indices,
   input  logic [DW-1:0]                    p2s_dout,
   input  logic [IDX_W-1:0]                 p2s_index,
   input  logic                             p2s_out_valid,
   output logic                             ser_valid,
   output logic [DW-1:0]                    ser_data,
   output logic [IDX_W-1:0]                 ser_index,
   output logic [OW-1:0]                    ser_owner,
   output logic                             ser_last,
   output logic                             busy,
   output logic                             err
);

   localparam logic [CW-1:0] LAST = CW'(BUS_WIDTH-1);

   sched_state_t       r_state;
   logic [CW-1:0]      r_cnt;
   logic [OW-1:0]      r_grant;
   logic               r_err;
   logic               r_in_valid;
   logic [NUM_REQ-1:0] r_ready;
   logic [OW-1:0]      w_win;
   logic               w_last;
   logic               w_take;

   assign w_last = (r_state == DRAIN) && (r_cnt == LAST);
   // A request seen on the final drain beat is arbitrated right away, so
   // back-to-back frames are separated only by the LOAD cycle.
   assign w_take = (|req_valid) && ((r_state == IDLE) || w_last);

   p2s_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef P2S_SCHED_RR_EN
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_advance (w_take),
`endif
      .i_req     (req_valid),
      .o_win     (w_win)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_grant    <= '0;
         r_err      <= 1'b0;
         r_in_valid <= 1'b0;
         r_ready    <= '0;
      end else begin
         r_in_valid <= 1'b0;
         r_ready    <= '0;
         if ((r_state == DRAIN) && !p2s_out_valid)
            r_err <= 1'b1;
         case (r_state)
            LOAD: begin
               r_state <= DRAIN;
               r_cnt   <= '0;
            end
            DRAIN: begin
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         if (w_take) begin
            r_state    <= LOAD;
            r_grant    <= w_win;
            r_in_valid <= 1'b1;
            r_ready    <= NUM_REQ'(1) << w_win;
         end
      end
   end

   // Frame bus idles at all-ones so a stray load strobe would be obvious downstream.
   always_comb begin
      p2s_din     = '1;
      p2s_indices = '1;
      if (r_in_valid) begin
         p2s_din     = req_data[int'(r_grant)*BUS_WIDTH*DW +: BUS_WIDTH*DW];
         p2s_indices = req_idx[int'(r_grant)*BUS_WIDTH*IDX_W +: BUS_WIDTH*IDX_W];
      end
   end

   assign p2s_in_valid = r_in_valid;
   assign req_ready    = r_ready;
   assign busy         = (r_state != IDLE);
   assign ser_valid    = p2s_out_valid && (r_state == DRAIN);
   assign ser_data     = p2s_dout;
   assign ser_index    = p2s_index;
   assign ser_owner    = r_grant;
   assign ser_last     = w_last;
   assign err          = r_err;

endmodule

// File: tb/tb_p2s_frame_scheduler.sv
// Bench for p2s_frame_scheduler: behavioural converter, beat scoreboard,
// table of arbitration scenarios plus late-arrival, reset and fault sequences.
module tb_p2s_frame_scheduler;
   localparam int DW = 32, BW = 12, NR = 2, IW = 4, OW = 1;

   logic                clk = 1'b0;
   logic                rstn;
   logic [NR-1:0]       req_valid, req_ready;
   logic [NR*BW*DW-1:0] req_data;
   logic [NR*BW*IW-1:0] req_idx;
   logic                p2s_in_valid;
   logic [BW*DW-1:0]    p2s_din;
   logic [BW*IW-1:0]    p2s_indices;
   logic [DW-1:0]       p2s_dout;
   logic [IW-1:0]       p2s_index;
   logic                p2s_out_valid;
   logic                ser_valid;
   logic [DW-1:0]       ser_data;
   logic [IW-1:0]       ser_index;
   logic [OW-1:0]       ser_owner;
   logic                ser_last, busy, err;

   always #5 clk = ~clk;

   p2s_frame_scheduler #(.DW(DW), .BUS_WIDTH(BW), .NUM_REQ(NR), .IDX_W(IW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_idx(req_idx),
      .p2s_in_valid(p2s_in_valid), .p2s_din(p2s_din), .p2s_indices(p2s_indices),
      .p2s_dout(p2s_dout), .p2s_index(p2s_index), .p2s_out_valid(p2s_out_valid),
      .ser_valid(ser_valid), .ser_data(ser_data), .ser_index(ser_index),
      .ser_owner(ser_owner), .ser_last(ser_last), .busy(busy), .err(err)
   );

   // Converter model: load on strobe, emit lanes 0..BW-1 on the following cycles.
   logic [BW*DW-1:0] m_frame = '0;
   logic [BW*IW-1:0] m_idx = '0;
   logic             m_act = 1'b0;
   int               m_k = 0;
   logic             fault_en = 1'b0;
   int               fault_k = 0;

   always @(posedge clk) begin
      if (!rstn) begin
         m_act <= 1'b0;
         m_k   <= 0;
      end else if (p2s_in_valid) begin
         m_frame <= p2s_din;
         m_idx   <= p2s_indices;
         m_k     <= 0;
         m_act   <= 1'b1;
      end else if (m_act) begin
         if (m_k == BW-1) m_act <= 1'b0;
         else             m_k   <= m_k + 1;
      end
   end

   assign p2s_out_valid = m_act && !(fault_en && (m_k == fault_k));
   assign p2s_dout      = m_frame[m_k*DW +: DW];
   assign p2s_index     = m_idx[m_k*IW +: IW];

   typedef struct {
      logic [DW-1:0] d;
      logic [IW-1:0] i;
      logic [OW-1:0] o;
      logic          l;
      int            lane;
   } beat_t;

   typedef struct {
      int         n0;
      int         n1;
      int         nfr;
      logic [7:0] own;
   } row_t;

   beat_t sb[$];
   int    ld_q[$];
   row_t  tbl[4];
   int    nchk = 0, nerr = 0, cyc = 0;
   int    left[NR];
   int    fs_cyc[8], fl_cyc[8];
   int    nfr_log = 0, prev_cyc = 0, prev_lane = 0;
   int    t0, t1;

   function automatic logic [DW-1:0] f_d(input int r, input int l);
      return DW'(32'h100 * (r + 1) + l);
   endfunction

   function automatic logic [IW-1:0] f_i(input int r, input int l);
      return IW'((r == 0) ? l : BW-1-l);
   endfunction

   function automatic logic [BW*DW-1:0] f_frame(input int r);
      logic [BW*DW-1:0] v;
      for (int l = 0; l < BW; l++) v[l*DW +: DW] = f_d(r, l);
      return v;
   endfunction

   function automatic logic [BW*IW-1:0] f_idx(input int r);
      logic [BW*IW-1:0] v;
      for (int l = 0; l < BW; l++) v[l*IW +: IW] = f_i(r, l);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int r, input int n);
      left[r]      = n;
      req_valid[r] = (n > 0);
   endtask

   task automatic expect_frame(input int r, input int skip);
      beat_t b;
      for (int l = 0; l < BW; l++) begin
         if (l != skip) begin
            b.d = f_d(r, l); b.i = f_i(r, l); b.o = OW'(r);
            b.l = (l == BW-1); b.lane = l;
            sb.push_back(b);
         end
      end
      ld_q.push_back(r);
   endtask

   task automatic monitor();
      beat_t b;
      int    r;
      chk("ready_vs_load", 64'(req_ready != '0), 64'(p2s_in_valid));
      if (p2s_in_valid) begin
         if (ld_q.size() == 0) chk("load_unexpected", 1, 0);
         else begin
            r = ld_q.pop_front();
            chk("ready_grant", 64'(req_ready), 64'(1) << r);
            chk("load_din", 64'(p2s_din == f_frame(r)), 1);
            chk("load_idx", 64'(p2s_indices == f_idx(r)), 1);
         end
      end
      if (ser_valid) begin
         if (sb.size() == 0) chk("unexpected_beat", 1, 0);
         else begin
            b = sb.pop_front();
            chk("beat_data", ser_data, b.d);
            chk("beat_idx", ser_index, b.i);
            chk("beat_owner", ser_owner, b.o);
            chk("beat_last", ser_last, b.l);
            if (b.lane == 0) begin
               if (nfr_log < 8) fs_cyc[nfr_log] = cyc;
            end else
               chk("beat_spacing", cyc - prev_cyc, b.lane - prev_lane);
            prev_cyc  = cyc;
            prev_lane = b.lane;
            if (b.l) begin
               if (nfr_log < 8) fl_cyc[nfr_log] = cyc;
               nfr_log++;
            end
         end
      end
   endtask

   task automatic tick();
      logic [NR-1:0] hs;
      @(negedge clk);
      monitor();
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         if (hs[r] && left[r] > 0) left[r]--;
         req_valid[r] = (left[r] > 0);
      end
      cyc++;
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (sb.size() > 0 && n < limit) begin
         tick();
         n++;
      end
      if (sb.size() > 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      fault_en = 1'b0;
      for (int r = 0; r < NR; r++) set_req(r, 0);
      tick();
      tick();
      sb.delete();
      ld_q.delete();
      nfr_log = 0;
      rstn = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_in_valid", p2s_in_valid, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_last", ser_last, 0);
      chk("rst_owner", ser_owner, 0);
      chk("rst_din_ones", 64'(p2s_din == '1), 1);
      chk("rst_idx_ones", 64'(p2s_indices == '1), 1);
   endtask

   initial begin
      // {n0, n1, frames, owner of frame f in bit f}
      tbl[0] = '{1, 0, 1, 8'b0000_0000};
      tbl[1] = '{0, 1, 1, 8'b0000_0001};
`ifdef P2S_SCHED_RR_EN
      tbl[2] = '{2, 2, 4, 8'b0000_1010};
`else
      tbl[2] = '{4, 1, 5, 8'b0001_0000};
`endif
      tbl[3] = '{1, 1, 2, 8'b0000_0010};

      rstn = 1'b0;
      req_valid = '0;
      for (int r = 0; r < NR; r++) begin
         left[r] = 0;
         for (int l = 0; l < BW; l++) begin
            req_data[(r*BW+l)*DW +: DW] = f_d(r, l);
            req_idx[(r*BW+l)*IW +: IW]  = f_i(r, l);
         end
      end
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 4; k++) begin
         do_reset();
         t0 = cyc;
         set_req(0, tbl[k].n0);
         set_req(1, tbl[k].n1);
         for (int f = 0; f < tbl[k].nfr; f++) expect_frame(int'(tbl[k].own[f]), -1);
         wait_drain(400);
         chk("nframes", nfr_log, tbl[k].nfr);
         chk("first_latency", fs_cyc[0] - t0, 2);
         for (int f = 1; f < tbl[k].nfr; f++) chk("frame_gap", fs_cyc[f] - fl_cyc[f-1], 2);
         chk("busy_after", busy, 0);
         chk("no_err", err, 0);
         chk("loads_done", ld_q.size(), 0);
      end

      // Late arrival on the last drain beat
      do_reset();
      t0 = cyc;
      set_req(0, 1);
      expect_frame(0, -1);
      expect_frame(1, -1);
      while (cyc < t0 + 13) tick();
      set_req(1, 1);
      wait_drain(100);
      chk("late_last_cyc", fl_cyc[0] - t0, 13);
      chk("late_gap", fs_cyc[1] - fl_cyc[0], 2);

      // Reset during beat 5 with requester 1 pending
      do_reset();
      t0 = cyc;
      set_req(0, 1);
      set_req(1, 1);
      expect_frame(0, -1);
      expect_frame(1, -1);
      while (cyc < t0 + 6) tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("midrst_busy", busy, 0);
      chk("midrst_ser_valid", ser_valid, 0);
      chk("midrst_err", err, 0);
      chk("midrst_beats_seen", BW*2 - sb.size(), 5);
      sb.delete();
      ld_q.delete();
      nfr_log = 0;
      expect_frame(1, -1);
      t1 = cyc;
      wait_drain(100);
      chk("midrst_regrant", fs_cyc[0] - t1, 2);
      chk("midrst_nframes", nfr_log, 1);

      // Converter drops valid on drain beat 3
      do_reset();
      fault_en = 1'b1;
      fault_k  = 3;
      t0 = cyc;
      set_req(0, 1);
      expect_frame(0, 3);
      while (cyc < t0 + 5) tick();
      chk("fault_err_before", err, 0);
      tick();
      chk("fault_err_set", err, 1);
      chk("fault_busy_mid", busy, 1);
      wait_drain(100);
      chk("fault_frame_len", fl_cyc[0] - t0, 13);
      chk("fault_busy_after", busy, 0);
      repeat (3) tick();
      chk("fault_err_sticky", err, 1);
      do_reset();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
